// File: rtl/ahb_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_dec_pkg
// Description : Shared types and encodings for the cipher-slave AHB decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_dec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KEY      = 3'd1,
        ST_DIN      = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_DOUT     = 3'd4,
        ST_HRDY     = 3'd5,
        ST_ERR1     = 3'd6,
        ST_ERR2     = 3'd7
    } dec_state_t;

    typedef enum logic [1:0] {
        XFER_ERR  = 2'd0,
        XFER_KEY  = 2'd1,
        XFER_DIN  = 2'd2,
        XFER_DOUT = 2'd3
    } xfer_kind_t;

    localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] C_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] C_HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] C_HSIZE_128 = 3'b100;

    localparam logic [31:0] C_BASE_ADDR = 32'h0000_0000;
    localparam logic [7:0]  C_OFF_KEY   = 8'h00;
    localparam logic [7:0]  C_OFF_DIN   = 8'h10;
    localparam logic [7:0]  C_OFF_DOUT  = 8'h20;

endpackage
`default_nettype wire

// File: rtl/ahb_addr_classify.sv
`default_nettype none
// ============================================================================
// Module      : ahb_addr_classify
// Description : Combinational classification of an AHB address phase into
//               key / data-in / result / error. Macro AHB_DEC_KEY_LOCK_EN
//               turns DIN/DOUT accesses before a key load into errors.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_addr_classify
    import ahb_dec_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = C_BASE_ADDR,
    parameter logic [7:0]  OFF_KEY   = C_OFF_KEY,
    parameter logic [7:0]  OFF_DIN   = C_OFF_DIN,
    parameter logic [7:0]  OFF_DOUT  = C_OFF_DOUT
) (
    input  logic [31:0] i_haddr,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
`ifdef AHB_DEC_KEY_LOCK_EN
    input  logic        i_key_loaded,
`endif
    output xfer_kind_t  o_kind
);

    logic w_size_ok;
    logic w_base_hit;

    assign w_size_ok  = (i_hsize == C_HSIZE_128);
    assign w_base_hit = (i_haddr[31:8] == BASE_ADDR[31:8]);

    always_comb begin
        o_kind = XFER_ERR;
        if (w_size_ok && w_base_hit) begin
            if (i_haddr[7:0] == OFF_KEY) begin
                o_kind = i_hwrite ? XFER_KEY : XFER_ERR;
            end else if (i_haddr[7:0] == OFF_DIN) begin
                o_kind = i_hwrite ? XFER_DIN : XFER_ERR;
            end else if (i_haddr[7:0] == OFF_DOUT) begin
                o_kind = i_hwrite ? XFER_ERR : XFER_DOUT;
            end
        end
`ifdef AHB_DEC_KEY_LOCK_EN
        // Data paths stay closed until the core has been keyed.
        if (!i_key_loaded && (o_kind == XFER_DIN || o_kind == XFER_DOUT)) begin
            o_kind = XFER_ERR;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/ahb_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ahb_addr_decoder
// Description : AHB-Lite address-phase decoder/pacer for the cipher slave.
//               Optional macro AHB_DEC_KEY_LOCK_EN enables the key lock.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_addr_decoder
    import ahb_dec_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = C_BASE_ADDR,
    parameter logic [7:0]  OFF_KEY   = C_OFF_KEY,
    parameter logic [7:0]  OFF_DIN   = C_OFF_DIN,
    parameter logic [7:0]  OFF_DOUT  = C_OFF_DOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic        data_done,
    input  logic        result_valid,
    output logic        readk_enable,
    output logic        read_enable,
    output logic        write_enable,
    output logic        hresp_error,
    output logic        hready_enable,
    output logic        key_loaded
);

    dec_state_t r_state;
    dec_state_t w_next;
    dec_state_t w_accept_state;
    xfer_kind_t w_kind;
    logic       r_key_loaded;
    logic       w_accept;

    assign w_accept = HSEL && HREADY &&
                      (HTRANS == C_HTRANS_NONSEQ || HTRANS == C_HTRANS_SEQ);

    ahb_addr_classify #(
        .BASE_ADDR (BASE_ADDR),
        .OFF_KEY   (OFF_KEY),
        .OFF_DIN   (OFF_DIN),
        .OFF_DOUT  (OFF_DOUT)
    ) u_classify (
        .i_haddr      (HADDR),
        .i_hwrite     (HWRITE),
        .i_hsize      (HSIZE),
`ifdef AHB_DEC_KEY_LOCK_EN
        .i_key_loaded (r_key_loaded),
`endif
        .o_kind       (w_kind)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_key_loaded <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_KEY && data_done) begin
                r_key_loaded <= 1'b1;
            end
        end
    end

    // State a freshly accepted transfer enters, shared by IDLE and HRDY.
    always_comb begin
        w_accept_state = ST_ERR1;
        case (w_kind)
            XFER_KEY:  w_accept_state = ST_KEY;
            XFER_DIN:  w_accept_state = ST_DIN;
            XFER_DOUT: w_accept_state = result_valid ? ST_DOUT : ST_WAIT_RES;
            default:   w_accept_state = ST_ERR1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept) w_next = w_accept_state;
            ST_KEY:      if (data_done) w_next = ST_HRDY;
            ST_DIN:      if (data_done) w_next = ST_HRDY;
            ST_DOUT:     if (data_done) w_next = ST_HRDY;
            ST_WAIT_RES: if (result_valid) w_next = ST_DOUT;
            ST_HRDY:     w_next = w_accept ? w_accept_state : ST_IDLE;
            ST_ERR1:     w_next = ST_ERR2;
            ST_ERR2:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Enables are pure decodes of the state register, so they stay mutually exclusive.
    assign readk_enable  = (r_state == ST_KEY);
    assign read_enable   = (r_state == ST_DIN);
    assign write_enable  = (r_state == ST_DOUT);
    assign hresp_error   = (r_state == ST_ERR1) || (r_state == ST_ERR2);
    assign hready_enable = (r_state == ST_HRDY) || (r_state == ST_ERR2);
    assign key_loaded    = r_key_loaded;

endmodule
`default_nettype wire

// File: tb/tb_ahb_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_addr_decoder
// Description : Self-checking bench for ahb_addr_decoder with a
//               transaction-level reference model (follows AHB_DEC_KEY_LOCK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_addr_decoder;

    localparam logic [31:0] C_BASE = 32'h4000_1000;
    localparam logic [1:0]  C_NONSEQ = 2'b10;
    localparam logic [1:0]  C_SEQ    = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b100;
    logic        HREADY = 1'b1;
    logic        data_done = 1'b0;
    logic        result_valid = 1'b0;
    logic        readk_enable, read_enable, write_enable;
    logic        hresp_error, hready_enable, key_loaded;

    int errors = 0;
    int checks = 0;
    bit exp_key = 1'b0;

    wire [5:0] obs = {readk_enable, read_enable, write_enable,
                      hresp_error, hready_enable, key_loaded};

    ahb_addr_decoder #(
        .BASE_ADDR (C_BASE),
        .OFF_KEY   (8'h00),
        .OFF_DIN   (8'h10),
        .OFF_DOUT  (8'h20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .HSEL          (HSEL),
        .HADDR         (HADDR),
        .HTRANS        (HTRANS),
        .HWRITE        (HWRITE),
        .HSIZE         (HSIZE),
        .HREADY        (HREADY),
        .data_done     (data_done),
        .result_valid  (result_valid),
        .readk_enable  (readk_enable),
        .read_enable   (read_enable),
        .write_enable  (write_enable),
        .hresp_error   (hresp_error),
        .hready_enable (hready_enable),
        .key_loaded    (key_loaded)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
    endtask

    // Kind codes: 0 error, 1 key, 2 data-in, 3 result read.
    function automatic int ref_kind(logic [31:0] a, logic w, logic [2:0] s, bit kl);
        int k;
        int off;
        k = 0;
        off = int'(a % 256);
        if (s == 3'd4 && (a / 256) == (C_BASE / 256)) begin
            if (off == 0 && w)       k = 1;
            else if (off == 16 && w) k = 2;
            else if (off == 32 && !w) k = 3;
        end
`ifdef AHB_DEC_KEY_LOCK_EN
        if ((k == 2 || k == 3) && !kl) k = 0;
`else
        if (kl) k = k;
`endif
        return k;
    endfunction

    // Issues one transfer starting in the current cycle and checks every cycle
    // of its response. With stay=1 it returns inside the HRDY cycle.
    task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                        input logic [2:0] s, input int wait_cyc, input int en_cyc,
                        input bit stay);
        int k;
        logic [5:0] exp_v;
        k = ref_kind(a, w, s, exp_key);
        HSEL = 1'b1; HADDR = a; HWRITE = w; HSIZE = s; HREADY = 1'b1;
        HTRANS = ($urandom_range(0, 1) == 1) ? C_NONSEQ : C_SEQ;
        result_valid = (k == 3) ? (wait_cyc == 0) : 1'($urandom_range(0, 1));
        tick();
        bus_idle();
        if (k == 0) begin
            exp_v = {5'b00010, exp_key};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s err1: got %b want %b", tag, obs, exp_v);
            end
            HSEL = 1'b1; HTRANS = C_NONSEQ; HADDR = C_BASE; HWRITE = 1'b1; HSIZE = 3'd4;
            tick();
            exp_v = {5'b00011, exp_key};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s err2: got %b want %b", tag, obs, exp_v);
            end
            tick();
            bus_idle();
            exp_v = {5'b00000, exp_key};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s err_idle: got %b want %b", tag, obs, exp_v);
            end
        end else begin
            if (k == 3) begin
                for (int i = 0; i < wait_cyc; i++) begin
                    exp_v = {5'b00000, exp_key};
                    checks++;
                    if (obs !== exp_v) begin
                        errors++;
                        $display("FAIL %s wait%0d: got %b want %b", tag, i, obs, exp_v);
                    end
                    data_done = 1'($urandom_range(0, 1));
                    result_valid = (i == wait_cyc - 1);
                    tick();
                    data_done = 1'b0;
                end
            end
            for (int i = 0; i < en_cyc; i++) begin
                exp_v = (k == 1) ? {5'b10000, exp_key} :
                        (k == 2) ? {5'b01000, exp_key} : {5'b00100, exp_key};
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL %s enable%0d: got %b want %b", tag, i, obs, exp_v);
                end
                if (k == 3) result_valid = 1'($urandom_range(0, 1));
                data_done = (i == en_cyc - 1);
                tick();
                data_done = 1'b0;
            end
            if (k == 1) exp_key = 1'b1;
            exp_v = {5'b00001, exp_key};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s hrdy: got %b want %b", tag, obs, exp_v);
            end
            if (!stay) begin
                tick();
                exp_v = {5'b00000, exp_key};
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL %s idle: got %b want %b", tag, obs, exp_v);
                end
            end
        end
    endtask

    task automatic apply_reset();
        bus_idle();
        data_done = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        exp_key = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", obs, 6'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b want %b", obs, 6'b0);
        end
    endtask

    task automatic test_no_select();
        for (int i = 0; i < 4; i++) begin
            HADDR = C_BASE; HWRITE = 1'b1; HSIZE = 3'd4;
            HSEL   = (i != 0);
            HTRANS = (i == 1) ? 2'b00 : (i == 2) ? 2'b01 : C_NONSEQ;
            HREADY = (i != 3);
            data_done = 1'b1;
            tick();
            bus_idle();
            HREADY = 1'b1;
            data_done = 1'b0;
            checks++;
            if (obs !== {5'b00000, exp_key}) begin
                errors++;
                $display("FAIL no_select%0d: got %b want %b", i, obs, {5'b00000, exp_key});
            end
        end
    endtask

    task automatic test_key_lock();
        apply_reset();
        xfer("din_before_key", C_BASE + 32'h10, 1'b1, 3'd4, 0, 1, 1'b0);
        xfer("key_write", C_BASE, 1'b1, 3'd4, 0, 2, 1'b0);
        xfer("din_after_key", C_BASE + 32'h10, 1'b1, 3'd4, 0, 1, 1'b0);
    endtask

    task automatic test_result_wait();
        xfer("dout_wait5", C_BASE + 32'h20, 1'b0, 3'd4, 5, 2, 1'b0);
        xfer("dout_ready", C_BASE + 32'h20, 1'b0, 3'd4, 0, 1, 1'b0);
    endtask

    task automatic test_errors();
        xfer("err_write_dout", C_BASE + 32'h20, 1'b1, 3'd4, 0, 1, 1'b0);
        xfer("err_size_din", C_BASE + 32'h10, 1'b1, 3'b010, 0, 1, 1'b0);
        xfer("err_read_key", C_BASE, 1'b0, 3'd4, 0, 1, 1'b0);
        xfer("err_unmapped", C_BASE + 32'h30, 1'b1, 3'd4, 0, 1, 1'b0);
        xfer("err_base", C_BASE ^ 32'h0010_0000, 1'b1, 3'd4, 0, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        xfer("b2b_key", C_BASE, 1'b1, 3'd4, 0, 1, 1'b1);
        xfer("b2b_din", C_BASE + 32'h10, 1'b1, 3'd4, 0, 2, 1'b1);
        xfer("b2b_dout", C_BASE + 32'h20, 1'b0, 3'd4, 1, 1, 1'b1);
        xfer("b2b_err", C_BASE + 32'h20, 1'b1, 3'd4, 0, 1, 1'b0);
    endtask

    task automatic test_async_reset();
        xfer("pre_key", C_BASE, 1'b1, 3'd4, 0, 1, 1'b0);
        HSEL = 1'b1; HTRANS = C_NONSEQ; HADDR = C_BASE + 32'h10; HWRITE = 1'b1; HSIZE = 3'd4;
        tick();
        bus_idle();
        checks++;
        if (obs !== 6'b010001) begin
            errors++;
            $display("FAIL arst_pre: got %b want %b", obs, 6'b010001);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL arst_same_cycle: got %b want %b", obs, 6'b0);
        end
        exp_key = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL arst_after: got %b want %b", obs, 6'b0);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [7:0]  offs [5];
        offs[0] = 8'h00; offs[1] = 8'h10; offs[2] = 8'h20; offs[3] = 8'h30; offs[4] = 8'h04;
        for (int n = 0; n < 40; n++) begin
            a = C_BASE | {24'h0, offs[$urandom_range(0, 4)]};
            if ($urandom_range(0, 9) == 0) a = a ^ (32'h1 << $urandom_range(8, 31));
            xfer("rand", a, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd4,
                 $urandom_range(0, 3), $urandom_range(1, 3),
                 (n != 39) && ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        test_reset();
        test_no_select();
        test_key_lock();
        test_result_wait();
        test_errors();
        test_back_to_back();
        test_no_select();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_addr_decoder.md
# ahb_addr_decoder

AHB-Lite address-phase decoder for the cipher slave. Samples HSEL/HADDR/HTRANS/HWRITE/HSIZE and classifies each transfer as key load, data-in load, result read or error. Drives the level enables (readk_enable, read_enable, write_enable, hresp_error, hready_enable) consumed by the downstream AHB data-phase stage, and paces them against that stage's completion pulse and the core's result-valid flag.

## Interface
- BASE_ADDR, 32'h0000_0000: slave base; decode uses HADDR[31:8] == BASE_ADDR[31:8]
- OFF_KEY, 8'h00: key register offset (master write only)
- OFF_DIN, 8'h10: data-in offset (master write only)
- OFF_DOUT, 8'h20: result offset (master read only)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  transfer address
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  1 = master write
- HSIZE  in  3  must be 3'b100 (128-bit)
- HREADY  in  1  global bus ready (address phase valid only when high)
- data_done  in  1  one-cycle pulse from data stage: bus data moved
- result_valid  in  1  cipher core output register holds a valid result
- readk_enable  out  1  data stage: capture HWDATA as key
- read_enable  out  1  data stage: capture HWDATA as data block
- write_enable  out  1  data stage: drive result onto HRDATA
- hresp_error  out  1  data stage: ERROR response
- hready_enable  out  1  data stage: complete transfer (HREADYOUT=1)
- key_loaded  out  1  a key has been written since reset

## Operation
- Accept = HSEL & HTRANS[1] & HREADY, sampled on clk rising edge, only in IDLE or HRDY. HTRANS IDLE/BUSY, or HSEL low: no action.
- Decode priority: HSIZE != 3'b100, base mismatch, unmapped offset, wrong direction (read of KEY/DIN, write of DOUT) -> ERR1. Else KEY / DIN / DOUT path.
- States: IDLE, KEY, DIN, WAIT_RES, DOUT, HRDY, ERR1, ERR2.
- KEY: readk_enable=1 until data_done; then key_loaded<=1, go HRDY.
- DIN: read_enable=1 until data_done; then HRDY.
- DOUT accept: result_valid=1 -> DOUT, else WAIT_RES (all enables 0) until result_valid=1 -> DOUT. DOUT: write_enable=1 until data_done; then HRDY.
- HRDY: hready_enable=1 for exactly one cycle; a new accept in this cycle decodes directly into its next state (back-to-back pipelined transfer), else IDLE.
- ERR1: hresp_error=1, hready_enable=0, one cycle -> ERR2. ERR2: hresp_error=1, hready_enable=1, one cycle -> IDLE (accepts ignored in ERR states; master must re-issue).
- At most one of readk/read/write/hresp_error high in any cycle; all outputs are registered (decoded from state register).
- data_done outside KEY/DIN/DOUT: ignored. result_valid dropping in DOUT: ignored (transfer completes).

## Timing
- Reset: state IDLE; all enables 0; key_loaded 0. Reset mid-transfer aborts immediately, no HRDY/ERR issued.
- Accept at edge N -> enable high from cycle N+1.
- data_done at edge M -> enable low, hready_enable high in cycle M+1, low in M+2 (unless next transfer accepted at M+1).
- Error: hresp_error high cycles N+1, N+2; hready_enable high cycle N+2 only.
- Minimum transfer: 3 cycles accept-to-HRDY when data_done arrives in first enable cycle.

## Configuration
- AHB_DEC_KEY_LOCK_EN defined: DIN or DOUT accept while key_loaded=0 -> ERR1/ERR2 error response.
- Not defined: key_loaded is reported only; DIN/DOUT are served regardless.

## Structure
- Shared package ahb_dec_pkg: state enum type, HTRANS and HSIZE encodings, default offset constants.
- One sub-module natural: ahb_addr_classify (combinational address/size/direction/key-lock check returning a transfer-kind enum); FSM in top.

## Test plan
- Write OFF_KEY, HSIZE=3'b100, data_done 2 cycles after enable -> readk_enable 2 cycles, hready_enable 1 cycle, key_loaded=1.
- Read OFF_DOUT with result_valid=0 for 5 cycles -> no enables for 5 cycles, then write_enable until data_done, then hready_enable.
- Write OFF_DOUT and HSIZE=3'b010 to OFF_DIN -> each gives hresp_error 2 cycles, hready_enable in second only.
- With AHB_DEC_KEY_LOCK_EN, write OFF_DIN after reset -> error; after key write, same access -> read_enable.
- Accept new NONSEQ in HRDY cycle -> next enable high in following cycle, no IDLE gap.
- Assert rst while read_enable high -> all outputs 0 same cycle (async), key_loaded 0.
